// File: rtl/xyolo_vwrite_pingpong_pkg.sv
// Shared types and helpers for the ping-pong YOLO write stage.
package xyolo_vwrite_pingpong_pkg;

   // Drain FSM states
   typedef enum logic [2:0] {
      DrIdle,
      DrRd,
      DrSend,
      DrBankEnd,
      DrDone
   } drain_state_e;

   // Index width that stays legal for a count of 1
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/xyolo_vwrite_pingpong_bank.sv
// Two-bank entry store: one write port, one registered read port.
// Bank select is the MSB of each address.
module xyolo_vwrite_pingpong_bank
   import xyolo_vwrite_pingpong_pkg::*;
#(
   parameter int unsigned W     = 256,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = idx_w(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [2*DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read, held between reads so beat data stays stable
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/xyolo_vwrite_pingpong.sv
// Ping-pong write stage: fills one bank from the lane array while the other
// drains to the databus. Optional stall counter enabled by VWB_STALL_CNT_EN.
module xyolo_vwrite_pingpong
   import xyolo_vwrite_pingpong_pkg::*;
#(
   parameter int unsigned DATAPATH_W = 32,
   parameter int unsigned NLANES     = 8,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned DATABUS_W  = 256,
   parameter int unsigned IO_ADDR_W  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run,
   output logic                         done,
   input  logic [IO_ADDR_W-1:0]         cfg_ext_addr,
   input  logic [$clog2(DEPTH):0]       cfg_n_entries,
   input  logic [15:0]                  cfg_n_banks,
   input  logic [IO_ADDR_W-1:0]         cfg_bank_stride,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NLANES*DATAPATH_W-1:0] in_data,
   output logic                         databus_valid,
   input  logic                         databus_ready,
   output logic [IO_ADDR_W-1:0]         databus_addr,
   output logic [DATABUS_W-1:0]         databus_wdata,
   output logic [DATABUS_W/8-1:0]       databus_wstrb
`ifdef VWB_STALL_CNT_EN
   ,
   output logic [31:0]                  stall_cnt
`endif
);

   localparam int unsigned ENTRY_W    = NLANES * DATAPATH_W;
   localparam int unsigned K          = ENTRY_W / DATABUS_W;
   localparam int unsigned IDX_W      = idx_w(DEPTH);
   localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
   localparam int unsigned BEAT_W     = idx_w(K);
   localparam int unsigned BEAT_BYTES = DATABUS_W / 8;

   drain_state_e state_q, state_d;

   logic                 active_q, done_q;
   logic                 fill_bank_q, drain_bank_q;
   logic [1:0]           full_q, full_d;
   logic [IDX_W-1:0]     wr_idx_q, rd_idx_q;
   logic [BEAT_W-1:0]    beat_q;
   logic [15:0]          fills_q, drained_q;
   logic [IO_ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]     n_entries_q;
   logic [15:0]          n_banks_q;
   logic [IO_ADDR_W-1:0] stride_q;

   logic               run_ok, cfg_empty, wr_fire, wr_last, accept;
   logic               beat_last, entry_last, bank_last, job_last;
   logic [ENTRY_W-1:0] rdata, beat_shift;

   // A run is only honoured when no job is in flight
   assign run_ok     = run && ((state_q == DrDone) || ((state_q == DrIdle) && !active_q));
   assign cfg_empty  = (cfg_n_entries == '0) || (cfg_n_banks == '0);
   assign in_ready   = active_q && !full_q[fill_bank_q] && (fills_q < n_banks_q);
   assign wr_fire    = in_valid && in_ready;
   assign wr_last    = wr_fire && (CNT_W'(wr_idx_q) == n_entries_q - CNT_W'(1));
   assign accept     = (state_q == DrSend) && databus_ready;
   assign beat_last  = (beat_q == BEAT_W'(K - 1));
   assign entry_last = (CNT_W'(rd_idx_q) == n_entries_q - CNT_W'(1));
   assign bank_last  = (drained_q == n_banks_q - 16'd1);
   assign job_last   = accept && beat_last && entry_last && bank_last;

   xyolo_vwrite_pingpong_bank #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH),
      .AW    (IDX_W + 1)
   ) u_bank (
      .clk   (clk),
      .we    (wr_fire),
      .waddr ({fill_bank_q, wr_idx_q}),
      .wdata (in_data),
      .re    (state_q == DrRd),
      .raddr ({drain_bank_q, rd_idx_q}),
      .rdata (rdata)
   );

   // Beat 0 is the most significant slice of the entry
   assign beat_shift    = rdata << (32'(beat_q) * DATABUS_W);
   assign databus_valid = (state_q == DrSend);
   assign databus_addr  = addr_q;
   assign databus_wdata = databus_valid ? beat_shift[ENTRY_W-1 -: DATABUS_W] : '0;
   assign databus_wstrb = databus_valid ? '1 : '0;
   assign done          = done_q;

   // Drain FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DrIdle:    if (active_q && full_q[drain_bank_q]) state_d = DrRd;
         DrRd:      state_d = DrSend;
         DrSend:    if (databus_ready) state_d = (beat_last && entry_last) ? DrBankEnd : DrRd;
         DrBankEnd: state_d = bank_last ? DrDone : DrIdle;
         DrDone:    state_d = DrDone;
         default:   state_d = DrIdle;
      endcase
      if (run_ok) state_d = cfg_empty ? DrDone : DrIdle;
   end

   // Bank full flags: set and clear may hit different banks in the same cycle
   always_comb begin
      full_d = full_q;
      if (wr_last) full_d[fill_bank_q] = 1'b1;
      if (state_q == DrBankEnd) full_d[drain_bank_q] = 1'b0;
   end

   // Drain FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= DrIdle;
      else     state_q <= state_d;
   end

   // Config, fill counter, drain counters and address generator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q     <= 1'b0;
         done_q       <= 1'b0;
         fill_bank_q  <= 1'b0;
         drain_bank_q <= 1'b0;
         full_q       <= '0;
         wr_idx_q     <= '0;
         rd_idx_q     <= '0;
         beat_q       <= '0;
         fills_q      <= '0;
         drained_q    <= '0;
         addr_q       <= '0;
         n_entries_q  <= '0;
         n_banks_q    <= '0;
         stride_q     <= '0;
      end else if (run_ok) begin
         active_q     <= !cfg_empty;
         done_q       <= cfg_empty;
         fill_bank_q  <= 1'b0;
         drain_bank_q <= 1'b0;
         full_q       <= '0;
         wr_idx_q     <= '0;
         rd_idx_q     <= '0;
         beat_q       <= '0;
         fills_q      <= '0;
         drained_q    <= '0;
         addr_q       <= cfg_ext_addr;
         n_entries_q  <= cfg_n_entries;
         n_banks_q    <= cfg_n_banks;
         stride_q     <= cfg_bank_stride;
      end else begin
         full_q <= full_d;
         if (wr_fire) begin
            if (wr_last) begin
               wr_idx_q    <= '0;
               fill_bank_q <= ~fill_bank_q;
               fills_q     <= fills_q + 16'd1;
            end else begin
               wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
         end
         if (accept) begin
            addr_q <= addr_q + IO_ADDR_W'(BEAT_BYTES);
            if (beat_last) begin
               beat_q   <= '0;
               rd_idx_q <= entry_last ? '0 : rd_idx_q + IDX_W'(1);
            end else begin
               beat_q <= beat_q + BEAT_W'(1);
            end
         end
         if (state_q == DrBankEnd) begin
            addr_q       <= addr_q + stride_q;
            drain_bank_q <= ~drain_bank_q;
            drained_q    <= drained_q + 16'd1;
            if (bank_last) active_q <= 1'b0;
         end
         if (job_last) done_q <= 1'b1;
      end
   end

`ifdef VWB_STALL_CNT_EN
   // Saturating count of cycles the databus holds off a valid beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                    stall_cnt <= '0;
      else if (run_ok)                                            stall_cnt <= '0;
      else if (databus_valid && !databus_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_xyolo_vwrite_pingpong.sv
// Scoreboard bench for xyolo_vwrite_pingpong (two beats per entry, small banks).
module tb_xyolo_vwrite_pingpong;

   localparam int unsigned DATAPATH_W = 32;
   localparam int unsigned NLANES     = 16;
   localparam int unsigned DEPTH      = 8;
   localparam int unsigned DATABUS_W  = 256;
   localparam int unsigned IO_ADDR_W  = 32;
   localparam int unsigned ENTRY_W    = NLANES * DATAPATH_W;
   localparam int unsigned K          = ENTRY_W / DATABUS_W;
   localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;

   typedef struct {
      logic [IO_ADDR_W-1:0] addr;
      logic [DATABUS_W-1:0] data;
   } beat_t;

   logic                   clk = 1'b0;
   logic                   rst, run, done;
   logic [IO_ADDR_W-1:0]   cfg_ext_addr, cfg_bank_stride;
   logic [CNT_W-1:0]       cfg_n_entries;
   logic [15:0]            cfg_n_banks;
   logic                   in_valid, in_ready;
   logic [ENTRY_W-1:0]     in_data;
   logic                   databus_valid, databus_ready;
   logic [IO_ADDR_W-1:0]   databus_addr;
   logic [DATABUS_W-1:0]   databus_wdata;
   logic [DATABUS_W/8-1:0] databus_wstrb;
`ifdef VWB_STALL_CNT_EN
   logic [31:0]            stall_cnt;
`endif

   int    checks = 0;
   int    failures = 0;
   bit    special_first = 1'b0;
   beat_t sb[$];

   always #5 clk = ~clk;

   xyolo_vwrite_pingpong #(
      .DATAPATH_W (DATAPATH_W),
      .NLANES     (NLANES),
      .DEPTH      (DEPTH),
      .DATABUS_W  (DATABUS_W),
      .IO_ADDR_W  (IO_ADDR_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .run             (run),
      .done            (done),
      .cfg_ext_addr    (cfg_ext_addr),
      .cfg_n_entries   (cfg_n_entries),
      .cfg_n_banks     (cfg_n_banks),
      .cfg_bank_stride (cfg_bank_stride),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .databus_valid   (databus_valid),
      .databus_ready   (databus_ready),
      .databus_addr    (databus_addr),
      .databus_wdata   (databus_wdata),
      .databus_wstrb   (databus_wstrb)
`ifdef VWB_STALL_CNT_EN
      ,
      .stall_cnt       (stall_cnt)
`endif
   );

   task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse run with a config; then drive lanes and databus ready per cycle
   // (on the falling edge), scoreboarding every accepted entry and beat.
   // rdy_mode: 0 ready always, 1 ready one cycle in four, 2 hold off the
   // first 7 valid cycles.
   task automatic run_job(input logic [31:0] ext, input int n_ent, input int nb,
                          input logic [31:0] stride, input int rdy_mode, input string name);
      int b = 0, e = 0, beats = 0, cyc = 0, last_cyc = -1, stalls = 0, vseen = 0, vcnt = 0;
      logic [ENTRY_W-1:0] ent;
      beat_t bt, got;
      @(negedge clk);
      cfg_ext_addr    = ext;
      cfg_n_entries   = CNT_W'(n_ent);
      cfg_n_banks     = 16'(nb);
      cfg_bank_stride = stride;
      run             = 1'b1;
      @(negedge clk);
      run = 1'b0;
      while (!done && cyc < 4000) begin
         case (rdy_mode)
            0:       databus_ready = 1'b1;
            1:       databus_ready = ((cyc % 4) == 3);
            default: begin
               databus_ready = (vcnt >= 7);
               if (databus_valid) vcnt++;
            end
         endcase
         for (int w = 0; w < int'(NLANES); w++) ent = {ent[ENTRY_W-33:0], 32'($urandom)};
         if (special_first && b == 0 && e == 0) ent = {{32{8'hAA}}, {32{8'hBB}}};
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = ent;
         if (in_valid && !in_ready && b < nb) stalls++;
         if (in_valid && in_ready) begin
            for (int j = 0; j < int'(K); j++) begin
               bt.addr = ext + 32'(((b * n_ent + e) * int'(K) + j) * 32) + stride * 32'(b);
               bt.data = ent[ENTRY_W - 1 - j * DATABUS_W -: DATABUS_W];
               sb.push_back(bt);
            end
            e++;
            if (e == n_ent) begin
               e = 0;
               b++;
            end
         end
         if (databus_valid) vseen++;
         if (databus_valid && databus_ready) begin
            check_val({name, "_sb_has_entry"}, (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               got = sb.pop_front();
               check_val({name, "_beat_addr"}, databus_addr, got.addr);
               check_val({name, "_beat_data"}, databus_wdata, got.data);
               check_val({name, "_beat_wstrb"}, databus_wstrb, {(DATABUS_W/8){1'b1}});
            end
            beats++;
            last_cyc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid      = 1'b0;
      databus_ready = 1'b0;
      check_val({name, "_done"}, done, 1);
      check_val({name, "_beat_count"}, beats, n_ent * nb * int'(K));
      check_val({name, "_sb_drained"}, sb.size(), 0);
      check_val({name, "_done_latency"}, cyc, (beats > 0) ? last_cyc + 1 : 0);
      if (n_ent == 0 || nb == 0) check_val({name, "_no_traffic"}, vseen, 0);
      if (rdy_mode == 1) check_val({name, "_fill_stalled"}, (stalls > 0), 1);
   endtask

   initial begin
      rst             = 1'b1;
      run             = 1'b0;
      cfg_ext_addr    = '0;
      cfg_n_entries   = '0;
      cfg_n_banks     = '0;
      cfg_bank_stride = '0;
      in_valid        = 1'b0;
      in_data         = '0;
      databus_ready   = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_done", done, 0);
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_valid", databus_valid, 0);
      check_val("rst_addr", databus_addr, 0);
      check_val("rst_wdata", databus_wdata, 0);
      check_val("rst_wstrb", databus_wstrb, 0);
      rst = 1'b0;

      // Single bank, 4 entries, first entry AA..|BB.. checks beat slice order
      special_first = 1'b1;
      run_job(32'h0000_0100, 4, 1, 32'h0, 0, "single");
      special_first = 1'b0;

      // Three full banks with a slow databus: fill must stall on both-full
      run_job(32'h0000_2000, int'(DEPTH), 3, 32'h1000, 1, "pingpong");

      // Empty job
      run_job(32'h0000_3000, 0, 2, 32'h0, 0, "empty");

      // Reset while a beat is waiting on the databus
      @(negedge clk);
      cfg_ext_addr  = 32'h0000_4000;
      cfg_n_entries = CNT_W'(2);
      cfg_n_banks   = 16'd1;
      run           = 1'b1;
      @(negedge clk);
      run           = 1'b0;
      in_valid      = 1'b1;
      databus_ready = 1'b0;
      for (int i = 0; i < 50 && !databus_valid; i++) @(negedge clk);
      check_val("midrst_reached_send", databus_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_val("midrst_valid", databus_valid, 0);
      check_val("midrst_done", done, 0);
      check_val("midrst_in_ready", in_ready, 0);
      check_val("midrst_wstrb", databus_wstrb, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      run_job(32'h0000_5000, 3, 2, 32'h40, 0, "after_rst");

`ifdef VWB_STALL_CNT_EN
      run_job(32'h0000_6000, 1, 1, 32'h0, 2, "stall");
      check_val("stall_cnt_seven", stall_cnt, 7);
      run_job(32'h0000_7000, 0, 1, 32'h0, 0, "stall_clear");
      check_val("stall_cnt_cleared", stall_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
